// File: rtl/ws_pixel_capture.sv
// rtl/ws_pixel_capture.sv - pixel capture and pass-through stage for a WS2812-style LED chain
//
// Captures the first NUM_PIXELS*BITS_PER_PIXEL decoded bits of each frame into a
// shadow register and forwards every later bit downstream. On the frame-reset gap
// the shadow is latched to o_pixels, or a frame error is flagged if capture was partial.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_bit/i_valid  decoded bit and its 1-cycle qualifier
//   i_treset       1-cycle reset/latch gap strobe
//   o_fwd_enable   1-cycle strobe, o_fwd_bit valid for downstream
//   o_fwd_bit      forwarded bit value (held between strobes)
//   o_fwd_treset   treset propagated downstream
//   o_pixels       latched pixel words, pixel 0 in the LSB word
//   o_latch        o_pixels updated this cycle
//   o_frame_err    frame ended while capture was incomplete
//   o_busy         capture in progress
module ws_pixel_capture #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int NUM_PIXELS     = 1,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_bit,
  input  logic                                 i_valid,
  input  logic                                 i_treset,
  output logic                                 o_fwd_enable,
  output logic                                 o_fwd_bit,
  output logic                                 o_fwd_treset,
  output logic [NUM_PIXELS*BITS_PER_PIXEL-1:0] o_pixels,
  output logic                                 o_latch,
  output logic                                 o_frame_err,
  output logic                                 o_busy
);

  localparam int BW    = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int PW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int TOTAL = NUM_PIXELS * BITS_PER_PIXEL;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_PASS    = 2'd2;

  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIXELS - 1);

  logic [1:0]       state;
  logic [BW-1:0]    bit_idx;
  logic [PW-1:0]    pix_idx;
  logic [TOTAL-1:0] shadow;
  logic [BW-1:0]    wr_bit;

  // Bit position inside the current word; counters sit at 0 in IDLE, so the
  // first bit of a frame lands at index 0 through the same path.
  assign wr_bit = MSB_FIRST ? (BIT_LAST - bit_idx) : bit_idx;
  assign o_busy = (state == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      pix_idx      <= '0;
      shadow       <= '0;
      o_fwd_enable <= 1'b0;
      o_fwd_bit    <= 1'b0;
      o_fwd_treset <= 1'b0;
      o_pixels     <= '0;
      o_latch      <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_fwd_enable <= 1'b0;
      o_fwd_treset <= 1'b0;
      o_latch      <= 1'b0;
      o_frame_err  <= 1'b0;

      // treset has priority: a bit arriving in the same cycle is dropped.
      if (i_treset) begin
        o_fwd_treset <= 1'b1;
        bit_idx      <= '0;
        pix_idx      <= '0;
        state        <= ST_IDLE;
        if (state == ST_PASS) begin
          o_pixels <= shadow;
          o_latch  <= 1'b1;
        end else if (state == ST_CAPTURE) begin
          o_frame_err <= 1'b1;
        end
      end else if (i_valid) begin
        if (state == ST_PASS) begin
          o_fwd_enable <= 1'b1;
          o_fwd_bit    <= i_bit;
        end else begin
          // Constant-index decoder keeps the write free of variable part-selects.
          for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int b = 0; b < BITS_PER_PIXEL; b++) begin
              if (pix_idx == PW'(p) && wr_bit == BW'(b)) begin
                shadow[p*BITS_PER_PIXEL + b] <= i_bit;
              end
            end
          end
          if (bit_idx == BIT_LAST) begin
            bit_idx <= '0;
            if (pix_idx == PIX_LAST) begin
              pix_idx <= '0;
              state   <= ST_PASS;
            end else begin
              pix_idx <= pix_idx + 1'b1;
              state   <= ST_CAPTURE;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            state   <= ST_CAPTURE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ws_pixel_capture.sv
// tb/tb_ws_pixel_capture.sv - testbench for ws_pixel_capture in three configurations
module tb_ws_pixel_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, i_bit, i_valid, i_treset;

  logic        fen_o [3];
  logic        fbit_o[3];
  logic        ftr_o [3];
  logic        lat_o [3];
  logic        err_o [3];
  logic        busy_o[3];
  logic [63:0] pix_o [3];

  logic [23:0] p0;
  logic [63:0] p1, p2;
  assign pix_o[0] = {40'd0, p0};
  assign pix_o[1] = p1;
  assign pix_o[2] = p2;

  ws_pixel_capture #(.BITS_PER_PIXEL(24), .NUM_PIXELS(1), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_bit(i_bit), .i_valid(i_valid), .i_treset(i_treset),
    .o_fwd_enable(fen_o[0]), .o_fwd_bit(fbit_o[0]), .o_fwd_treset(ftr_o[0]),
    .o_pixels(p0), .o_latch(lat_o[0]), .o_frame_err(err_o[0]), .o_busy(busy_o[0]));

  ws_pixel_capture #(.BITS_PER_PIXEL(32), .NUM_PIXELS(2), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_bit(i_bit), .i_valid(i_valid), .i_treset(i_treset),
    .o_fwd_enable(fen_o[1]), .o_fwd_bit(fbit_o[1]), .o_fwd_treset(ftr_o[1]),
    .o_pixels(p1), .o_latch(lat_o[1]), .o_frame_err(err_o[1]), .o_busy(busy_o[1]));

  ws_pixel_capture #(.BITS_PER_PIXEL(32), .NUM_PIXELS(2), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_bit(i_bit), .i_valid(i_valid), .i_treset(i_treset),
    .o_fwd_enable(fen_o[2]), .o_fwd_bit(fbit_o[2]), .o_fwd_treset(ftr_o[2]),
    .o_pixels(p2), .o_latch(lat_o[2]), .o_frame_err(err_o[2]), .o_busy(busy_o[2]));

  // Reference model: a frame is a count of accepted bits plus the captured image.
  int tot [3] = '{24, 64, 64};
  int bpp [3] = '{24, 32, 32};
  bit msbf[3] = '{1'b1, 1'b1, 1'b0};

  int          n     [3];
  logic [63:0] cap   [3];
  logic [63:0] e_pix [3];
  logic        e_fen [3];
  logic        e_fbit[3];
  logic        e_tr  [3];
  logic        e_lat [3];
  logic        e_err [3];
  logic        e_busy[3];

  int errors = 0;
  int checks = 0;
  int lat_cnt0, fen_cnt0;
  logic [63:0] fwd_word0;

  task automatic chk(input string tag, input int c, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: got %h want %h", tag, c, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic v, input logic t);
    rst_n = r; i_bit = b; i_valid = v; i_treset = t;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (!r) begin
        n[c] = 0; cap[c] = '0; e_pix[c] = '0;
        e_fen[c] = 0; e_fbit[c] = 0; e_tr[c] = 0; e_lat[c] = 0; e_err[c] = 0;
      end else begin
        e_fen[c] = 0; e_tr[c] = 0; e_lat[c] = 0; e_err[c] = 0;
        if (t) begin
          e_tr[c] = 1;
          if (n[c] >= tot[c]) begin
            e_pix[c] = cap[c];
            e_lat[c] = 1;
          end else if (n[c] > 0) begin
            e_err[c] = 1;
          end
          n[c] = 0;
        end else if (v) begin
          if (n[c] >= tot[c]) begin
            e_fen[c] = 1;
            e_fbit[c] = b;
          end else begin
            int k, j, pos;
            k = n[c] / bpp[c];
            j = n[c] % bpp[c];
            pos = msbf[c] ? bpp[c] - 1 - j : j;
            cap[c][k*bpp[c] + pos] = b;
            n[c]++;
          end
        end
      end
      e_busy[c] = (n[c] > 0) && (n[c] < tot[c]);
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("fwd_enable", c, 64'(fen_o[c]), 64'(e_fen[c]));
      chk("fwd_bit", c, 64'(fbit_o[c]), 64'(e_fbit[c]));
      chk("fwd_treset", c, 64'(ftr_o[c]), 64'(e_tr[c]));
      chk("latch", c, 64'(lat_o[c]), 64'(e_lat[c]));
      chk("frame_err", c, 64'(err_o[c]), 64'(e_err[c]));
      chk("busy", c, 64'(busy_o[c]), 64'(e_busy[c]));
      chk("pixels", c, pix_o[c], e_pix[c]);
    end
    if (lat_o[0]) lat_cnt0++;
    if (fen_o[0]) begin
      fen_cnt0++;
      fwd_word0 = {fwd_word0[62:0], fbit_o[0]};
    end
  endtask

  task automatic send(input logic [63:0] val, input int nb);
    for (int i = nb - 1; i >= 0; i--) step(1'b1, val[i], 1'b1, 1'b0);
  endtask

  task automatic clear_counts();
    lat_cnt0 = 0; fen_cnt0 = 0; fwd_word0 = '0;
  endtask

  initial begin
    rst_n = 1'b0; i_bit = 1'b0; i_valid = 1'b0; i_treset = 1'b0;
    clear_counts();

    // Reset held for two cycles
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pixels", 0, pix_o[0], 64'd0);
    chk("reset_busy", 0, 64'(busy_o[0]), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Single exact frame
    clear_counts();
    send(64'h123456, 24);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_pixels", 0, pix_o[0], 64'h123456);
    chk("t2_latch_count", 0, 64'(lat_cnt0), 64'd1);
    chk("t2_fwd_count", 0, 64'(fen_cnt0), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Partial frame after a good one, then a clean frame
    send(64'h3FF, 10);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_err", 0, 64'(err_o[0]), 64'd1);
    chk("t4_hold", 0, pix_o[0], 64'h123456);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_err_clear", 0, 64'(err_o[0]), 64'd0);
    send(64'h0F0F0F, 24);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_pixels", 0, pix_o[0], 64'h0F0F0F);

    // Capture plus 24 forwarded bits
    clear_counts();
    send(64'hAABBCC010203, 48);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_pixels", 0, pix_o[0], 64'hAABBCC);
    chk("t3_fwd_count", 0, 64'(fen_cnt0), 64'd24);
    chk("t3_fwd_word", 0, fwd_word0, 64'h010203);

    // Two 32-bit pixels, both bit orders
    send(64'h1122334455667788, 64);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_msb", 1, pix_o[1], 64'h55667788_11223344);
    chk("t5_lsb_word0", 2, 64'(pix_o[2][31:0]), 64'h22CC4488);

    // Reset mid-capture, then a fresh frame
    send(64'hABC, 12);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_reset_pixels", 0, pix_o[0], 64'd0);
    send(64'hFFFFFF, 24);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_pixels", 0, pix_o[0], 64'hFFFFFF);

    // valid and treset together while passing
    clear_counts();
    send(64'h2AAAAAAA, 30);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_vt_latch", 0, 64'(lat_o[0]), 64'd1);
    chk("t6_vt_nofwd", 0, 64'(fen_o[0]), 64'd0);
    chk("t6_vt_fwd_count", 0, 64'(fen_cnt0), 64'd6);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 299) != 0, 1'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 89) == 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
